memory_stream_reader: RTL and testbench

- Read-side engine for the team's simple dual-port memory: drives the memory's read address and consumes its registered read data.
- Streams a block of words, from a start address for a word count, onto a valid/ready output stream.
- Absorbs the memory's fixed 1-cycle read latency and downstream backpressure with a 2-entry output buffer. Sustains 1 word/cycle with no loss or duplication.
- Sits between a memory block and any stream consumer (UART TX, DMA, display fetch).

---
 rtl/memory_stream_reader.sv | 172 +++++++++++++++++
 tb/tb_memory_stream_reader.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stream_reader.sv
// Streams a block of words out of a 1-cycle-latency memory onto a valid/ready stream.
// Optional STREAM_READER_LAST_EN adds a dataLast output marking the final word of a burst.
module memory_stream_reader #(
    parameter int DATAWIDTH    = 8,
    parameter int DATADEPTH    = 1024,
    parameter int ADDRESSWIDTH = $clog2(DATADEPTH)
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    start,
    input  logic [ADDRESSWIDTH-1:0] startAddress,
    input  logic [ADDRESSWIDTH:0]   wordCount,
    output logic                    busy,
    output logic                    done,
    output logic [ADDRESSWIDTH-1:0] memReadAddress,
    input  logic [DATAWIDTH-1:0]    memDataIn,
    output logic [DATAWIDTH-1:0]    dataOut,
    output logic                    dataValid,
    input  logic                    dataReady
`ifdef STREAM_READER_LAST_EN
    ,
    output logic                    dataLast
`endif
);

    // Stream handshake: a word moves when dataValid && dataReady at a rising edge;
    // while dataValid is high and dataReady low, dataOut (and dataLast) hold.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [ADDRESSWIDTH-1:0] LAST_ADDR = ADDRESSWIDTH'(DATADEPTH - 1);

    state_t                  state;
    logic [ADDRESSWIDTH-1:0] addr_reg;
    logic [ADDRESSWIDTH:0]   remaining;
    logic                    inflight;
    logic [1:0]              occ;
    logic [DATAWIDTH-1:0]    buf0;
    logic [DATAWIDTH-1:0]    buf1;
    logic                    busy_r;
    logic                    done_r;
`ifdef STREAM_READER_LAST_EN
    logic                    inflight_last;
    logic                    last0;
    logic                    last1;
`endif

    logic       pop;
    logic       issue;
    logic [1:0] occ_next;

    assign dataValid      = (occ != 2'd0);
    assign dataOut        = buf0;
    assign memReadAddress = addr_reg;
    assign busy           = busy_r;
    assign done           = done_r;
`ifdef STREAM_READER_LAST_EN
    assign dataLast       = last0 && dataValid;
`endif

    assign pop = dataValid && dataReady;

    // A read may issue only if the word it returns is guaranteed a buffer slot.
    assign issue = (state == S_RUN) && (remaining != '0) &&
                   (({1'b0, occ} + {2'b0, inflight}) <= (3'd1 + {2'b0, pop}));

    assign occ_next = occ + {1'b0, inflight} - {1'b0, pop};

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state     <= S_IDLE;
            addr_reg  <= '0;
            remaining <= '0;
            inflight  <= 1'b0;
            occ       <= 2'd0;
            buf0      <= '0;
            buf1      <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
`ifdef STREAM_READER_LAST_EN
            inflight_last <= 1'b0;
            last0         <= 1'b0;
            last1         <= 1'b0;
`endif
        end else begin
            inflight <= issue;
            if (issue) begin
                remaining <= remaining - 1'b1;
                addr_reg  <= (addr_reg == LAST_ADDR) ? '0 : addr_reg + 1'b1;
`ifdef STREAM_READER_LAST_EN
                inflight_last <= (remaining == 1);
`endif
            end

            // Two-entry FIFO: buf0 is the head, buf1 the second entry.
            case ({inflight, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        buf0 <= memDataIn;
`ifdef STREAM_READER_LAST_EN
                        last0 <= inflight_last;
`endif
                    end else begin
                        buf1 <= memDataIn;
`ifdef STREAM_READER_LAST_EN
                        last1 <= inflight_last;
`endif
                    end
                end
                2'b01: begin
                    buf0 <= buf1;
`ifdef STREAM_READER_LAST_EN
                    last0 <= last1;
`endif
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        buf0 <= memDataIn;
`ifdef STREAM_READER_LAST_EN
                        last0 <= inflight_last;
`endif
                    end else begin
                        buf0 <= buf1;
                        buf1 <= memDataIn;
`ifdef STREAM_READER_LAST_EN
                        last0 <= last1;
                        last1 <= inflight_last;
`endif
                    end
                end
                default: ;
            endcase
            occ <= occ_next;

            case (state)
                S_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        addr_reg  <= startAddress;
                        remaining <= wordCount;
                        if (wordCount != '0) begin
                            state  <= S_RUN;
                            busy_r <= 1'b1;
                        end else begin
                            state  <= S_DONE;
                            done_r <= 1'b1;
                            busy_r <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    // Finish on the edge that drains the last word so done follows it directly.
                    if (remaining == '0 && !inflight && occ_next == 2'd0) begin
                        state  <= S_DONE;
                        done_r <= 1'b1;
                        busy_r <= 1'b0;
                    end
                end
                S_DONE: begin
                    done_r <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_stream_reader.sv
// Directed bench for memory_stream_reader: memory model, ready pattern driver,
// stream monitor with an expected-word queue, and a one-line summary.
module tb_memory_stream_reader;

    localparam int DW = 8;
    localparam int DD = 1024;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          resetN = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] startAddress = '0;
    logic [AW:0]   wordCount = '0;
    logic          busy;
    logic          done;
    logic [AW-1:0] memReadAddress;
    logic [DW-1:0] mem_data = '0;
    logic [DW-1:0] dataOut;
    logic          dataValid;
    logic          dataReady = 1'b1;
`ifdef STREAM_READER_LAST_EN
    logic          dataLast;
`endif

    memory_stream_reader #(.DATAWIDTH(DW), .DATADEPTH(DD)) dut (
        .clk(clk),
        .resetN(resetN),
        .start(start),
        .startAddress(startAddress),
        .wordCount(wordCount),
        .busy(busy),
        .done(done),
        .memReadAddress(memReadAddress),
        .memDataIn(mem_data),
        .dataOut(dataOut),
        .dataValid(dataValid),
        .dataReady(dataReady)
`ifdef STREAM_READER_LAST_EN
        ,
        .dataLast(dataLast)
`endif
    );

    // clock / reset block
    always #5 clk = ~clk;

    logic [DW-1:0] mem [DD];
    initial for (int i = 0; i < DD; i++) mem[i] = DW'(i & 8'hFF);
    always @(posedge clk) mem_data <= mem[memReadAddress];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard state
    logic [DW-1:0] exp_q[$];
    logic          exp_last_q[$];
    int n_tests = 0;
    int n_fail = 0;
    int xfers = 0;
    int first_valid_cyc = -1;
    int last_xfer_cyc = -1;
    int done_cnt = 0;
    int done_cyc = -1;
    int done0 = 0;
    int start_cyc = 0;
    logic busy_at_done = 1'b0;
    logic saw_zero = 1'b0;
    logic ready_mode = 1'b0;
    logic [31:0] ready_pat = 32'b1011_0000_0110_1110_0101_1100_1001_1101;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ready driver
    initial begin
        int pidx = 0;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode) begin
                dataReady = ready_pat[pidx];
                pidx = (pidx + 1) % 32;
            end else begin
                dataReady = 1'b1;
            end
        end
    end

    // stream monitor
    always @(negedge clk) begin
        if (resetN) begin
            if (dataValid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_word", exp_q.size(), 1);
                end else begin
                    check("data", dataOut, exp_q[0]);
`ifdef STREAM_READER_LAST_EN
                    check("last", dataLast, exp_last_q[0]);
`endif
                    if (dataReady) begin
                        void'(exp_q.pop_front());
                        void'(exp_last_q.pop_front());
                        xfers++;
                        last_xfer_cyc = cyc;
                    end
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                busy_at_done = busy;
            end
            if (busy && memReadAddress == '0) saw_zero = 1'b1;
        end
    end

    task automatic launch(input int addr, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            exp_q.push_back(mem[(addr + i) % DD]);
            exp_last_q.push_back(i == cnt - 1);
        end
        xfers = 0;
        first_valid_cyc = -1;
        last_xfer_cyc = -1;
        done0 = done_cnt;
        saw_zero = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b1;
        startAddress = AW'(addr);
        wordCount = (AW + 1)'(cnt);
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_cnt == done0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check({tag, "_done_once"}, done_cnt - done0, 1);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
        check({tag, "_busy_at_done"}, busy_at_done, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", dataValid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_data", dataOut, 0);
        check("rst_addr", memReadAddress, 0);
        resetN = 1'b1;

        // basic 4-word burst with ready held high
        launch(10, 4);
        wait_done("basic");
        check("basic_first_valid", first_valid_cyc, start_cyc + 3);
        check("basic_back_to_back", last_xfer_cyc, first_valid_cyc + 3);
        check("basic_done_timing", done_cyc, last_xfer_cyc + 1);
        check("basic_count", xfers, 4);

        // address wrap at the top of memory
        launch(1022, 4);
        wait_done("wrap");
        check("wrap_addr_zero", saw_zero, 1);
        check("wrap_count", xfers, 4);

        // backpressure with a 5-cycle stall in the pattern
        ready_mode = 1'b1;
        launch(100, 16);
        wait_done("stall");
        check("stall_count", xfers, 16);
        check("stall_done_timing", done_cyc, last_xfer_cyc + 1);
        ready_mode = 1'b0;

        // zero-length burst
        launch(5, 0);
        wait_done("zero");
        check("zero_done_timing", done_cyc, start_cyc + 1);
        check("zero_no_words", xfers, 0);

        // start while busy is ignored
        launch(20, 4);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        startAddress = AW'(300);
        wordCount = (AW + 1)'(7);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("ignore");
        check("ignore_count", xfers, 4);

        // reset in the middle of a burst
        launch(40, 8);
        begin
            int n = 0;
            while (xfers < 2 && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        check("midrst_reached", xfers >= 2, 1);
        @(posedge clk);
        #1;
        resetN = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_valid", dataValid, 0);
        check("midrst_data", dataOut, 0);
        check("midrst_addr", memReadAddress, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        resetN = 1'b1;
        exp_q.delete();
        exp_last_q.delete();
        done0 = done_cnt;
        repeat (5) @(negedge clk);
        check("midrst_no_done", done_cnt - done0, 0);
        launch(0, 2);
        wait_done("after_rst");
        check("after_rst_count", xfers, 2);

`ifdef STREAM_READER_LAST_EN
        ready_mode = 1'b1;
        launch(50, 3);
        wait_done("last3");
        check("last3_count", xfers, 3);
        launch(60, 1);
        wait_done("last1");
        check("last1_count", xfers, 1);
        ready_mode = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
